// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a 5-byte command packet parser {A5, CMD, ARG_HI, ARG_LO, SUM}.
// Good packets update cmd/arg with a one-cycle strobe; framing and checksum errors strobe separately.
module uart_cmd_rx #(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  cmd,
  output logic [15:0] arg,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        chk_err,
  output logic        busy
);

  localparam int CW = $clog2(BAUD_DIV * TIMEOUT_BITS) + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(BAUD_DIV * TIMEOUT_BITS - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_AH, P_AL, P_SUM} parse_state_e;

  byte_state_e  bstate_q;
  parse_state_e pstate_q;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] baud_q, tmo_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, cmd_sh_q, ah_q, al_q, cmd_q;
  logic [15:0]   arg_q;
  logic          cmd_valid_q, frame_err_q, chk_err_q;

  logic       start_edge, stop_sample, byte_ok_d, frame_err_d, timeout_d;
  logic [7:0] sum_d;

  // A start edge is only a 1->0 transition, so a held-low line (break) cannot retrigger.
  assign start_edge  = (bstate_q == B_IDLE) && rx_prev_q && !rx_s_q;
  assign stop_sample = (bstate_q == B_STOP) && (baud_q == BIT_LAST);
  assign byte_ok_d   = stop_sample && rx_s_q;
  assign frame_err_d = stop_sample && !rx_s_q;
  assign timeout_d   = (pstate_q != P_HDR) && (tmo_q == TMO_LAST);
  assign sum_d       = cmd_sh_q + ah_q + al_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      bstate_q    <= B_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      frame_err_q <= frame_err_d;
      unique case (bstate_q)
        B_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (start_edge) bstate_q <= B_START;
        end
        B_START: begin
          if (baud_q == HALF_LAST) begin
            baud_q   <= '0;
            bstate_q <= rx_s_q ? B_IDLE : B_DATA;
          end else begin
            baud_q <= baud_q + ONE;
          end
        end
        B_DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) bstate_q <= B_STOP;
          end else begin
            baud_q <= baud_q + ONE;
          end
        end
        B_STOP: begin
          if (baud_q == BIT_LAST) begin
            baud_q   <= '0;
            bstate_q <= B_IDLE;
          end else begin
            baud_q <= baud_q + ONE;
          end
        end
        default: bstate_q <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q    <= P_HDR;
      tmo_q       <= '0;
      cmd_sh_q    <= '0;
      ah_q        <= '0;
      al_q        <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      if (pstate_q == P_HDR || start_edge) tmo_q <= '0;
      else if (tmo_q != TMO_LAST)          tmo_q <= tmo_q + ONE;

      if (frame_err_d) begin
        pstate_q <= P_HDR;
      end else if (byte_ok_d) begin
        unique case (pstate_q)
          P_HDR: if (shift_q == 8'hA5) pstate_q <= P_CMD;
          P_CMD: begin cmd_sh_q <= shift_q; pstate_q <= P_AH;  end
          P_AH:  begin ah_q     <= shift_q; pstate_q <= P_AL;  end
          P_AL:  begin al_q     <= shift_q; pstate_q <= P_SUM; end
          P_SUM: begin
            if (shift_q == sum_d) begin
              cmd_q       <= cmd_sh_q;
              arg_q       <= {ah_q, al_q};
              cmd_valid_q <= 1'b1;
            end else begin
              chk_err_q <= 1'b1;
            end
            pstate_q <= P_HDR;
          end
          default: pstate_q <= P_HDR;
        endcase
      end else if (timeout_d) begin
        pstate_q <= P_HDR;
      end
    end
  end

  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign chk_err   = chk_err_q;
  assign busy      = (bstate_q != B_IDLE) || (pstate_q != P_HDR);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a table of packets plus hand-written sequences for
// framing error, timeout, glitch, break and reset-mid-packet cases.
module tb_uart_cmd_rx;

  localparam int BD = 16;
  localparam int TB = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        cmd_valid, frame_err, chk_err, busy;

  uart_cmd_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cmd(cmd), .arg(arg),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .chk_err(chk_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_chk = 0, n_frame = 0, rule_viol = 0;
  logic prev_v = 1'b0, prev_c = 1'b0, prev_f = 1'b0;

  // Strobe monitor: counts pulses and flags overlap or back-to-back strobes.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0; prev_c = 1'b0; prev_f = 1'b0;
    end else begin
      if (cmd_valid) n_valid++;
      if (chk_err)   n_chk++;
      if (frame_err) n_frame++;
      if ((int'(cmd_valid) + int'(chk_err) + int'(frame_err)) > 1) rule_viol++;
      if ((cmd_valid && prev_v) || (chk_err && prev_c) || (frame_err && prev_f)) rule_viol++;
      prev_v = cmd_valid; prev_c = chk_err; prev_f = frame_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_bytes(input logic [47:0] bytes, input int n);
    for (int k = 0; k < n; k++) send_byte(bytes[47 - 8 * k -: 8]);
  endtask

  typedef struct {
    int          n;
    logic [47:0] bytes;
    int          exp_valid;
    int          exp_chk;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_arg;
  } vec_t;

  vec_t vecs[5];
  int v0, c0, f0;

  initial begin
    vecs[0] = '{5, 48'hA5_01_12_34_47_00, 1, 0, 8'h01, 16'h1234};
    vecs[1] = '{5, 48'hA5_01_12_34_48_00, 0, 1, 8'h01, 16'h1234};
    vecs[2] = '{5, 48'hA5_7F_A5_A5_C9_00, 1, 0, 8'h7F, 16'hA5A5};
    vecs[3] = '{5, 48'hA5_FF_FF_FF_FD_00, 1, 0, 8'hFF, 16'hFFFF};
    vecs[4] = '{6, 48'h3C_A5_10_00_01_11, 1, 0, 8'h10, 16'h0001};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd, arg, cmd_valid, frame_err, chk_err, busy}, 32'h0);
    rst = 1'b0;
    idle_bits(2);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; c0 = n_chk; f0 = n_frame;
      send_bytes(vecs[i].bytes, vecs[i].n);
      idle_bits(2);
      check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_chk", i),   n_chk - c0,   vecs[i].exp_chk);
      check($sformatf("vec%0d_frame", i), n_frame - f0, 0);
      check($sformatf("vec%0d_cmd", i),   cmd,          vecs[i].exp_cmd);
      check($sformatf("vec%0d_arg", i),   arg,          vecs[i].exp_arg);
    end

    // Framing error mid-packet, then a clean packet.
    v0 = n_valid; c0 = n_chk; f0 = n_frame;
    send_bytes(48'hA5_01_00_00_00_00, 2);
    send_byte(8'h12, 1'b0);
    idle_bits(2);
    send_bytes(48'hA5_02_00_05_07_00, 5);
    idle_bits(2);
    check("ferr_frame", n_frame - f0, 1);
    check("ferr_valid", n_valid - v0, 1);
    check("ferr_chk",   n_chk - c0,   0);
    check("ferr_cmdarg", {cmd, arg}, {8'h02, 16'h0005});

    // Inter-byte timeout: trailing bytes must not complete the stale packet.
    v0 = n_valid; c0 = n_chk;
    send_bytes(48'hA5_03_00_00_00_00, 2);
    @(negedge clk);
    check("tmo_busy_before", busy, 1'b1);
    idle_bits(25);
    check("tmo_busy_after", busy, 1'b0);
    send_bytes(48'h00_00_03_00_00_00, 3);
    idle_bits(2);
    check("tmo_valid", n_valid - v0, 0);
    check("tmo_chk",   n_chk - c0,   0);
    check("tmo_cmdarg", {cmd, arg}, {8'h02, 16'h0005});

    // Short low glitch is rejected without an error.
    v0 = n_valid; c0 = n_chk; f0 = n_frame;
    rx = 1'b0;
    repeat (BD / 4) @(negedge clk);
    idle_bits(2);
    check("glitch_frame", n_frame - f0, 0);
    check("glitch_strobes", (n_valid - v0) + (n_chk - c0), 0);
    check("glitch_busy", busy, 1'b0);
    send_bytes(48'hA5_05_00_02_07_00, 5);
    idle_bits(2);
    check("glitch_pkt_valid", n_valid - v0, 1);
    check("glitch_pkt_cmdarg", {cmd, arg}, {8'h05, 16'h0002});

    // Break: exactly one framing error while the line stays low.
    f0 = n_frame; v0 = n_valid;
    rx = 1'b0;
    repeat (20 * BD) @(negedge clk);
    check("break_frame", n_frame - f0, 1);
    idle_bits(2);
    check("break_valid", n_valid - v0, 0);
    check("break_busy", busy, 1'b0);

    // Reset in the middle of the ARG_LO byte.
    send_bytes(48'hA5_04_00_00_00_00, 3);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {cmd, arg, cmd_valid, frame_err, chk_err, busy}, 32'h0);
    rst = 1'b0;
    idle_bits(2);
    v0 = n_valid; c0 = n_chk; f0 = n_frame;
    send_bytes(48'hA5_04_00_01_05_00, 5);
    idle_bits(2);
    check("rst_pkt_valid", n_valid - v0, 1);
    check("rst_pkt_errs", (n_chk - c0) + (n_frame - f0), 0);
    check("rst_pkt_cmdarg", {cmd, arg}, {8'h04, 16'h0001});

    check("strobe_rules", rule_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
